// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone SDRAM arbiter: FSM state, grant index
// and the Wishbone cycle-type constants.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1,
    StAbort
  } arb_state_e;

  // Index of a master: 0 = instruction port, 1 = data port.
  typedef logic gnt_idx_t;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

endpackage

// File: rtl/wb_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the prio pointer.
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  gnt_idx_t   prio_i,
  output gnt_idx_t   idx_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = 1'b0;
    case (req_i)
      2'b10:   idx_o = 1'b1;
      2'b11:   idx_o = prio_i;
      default: idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of a single SDRAM-controller slave, with bus lock
// for the granted cycle. Optional ack watchdog is compiled in by WB_SDRAM_ARBITER_TIMEOUT_EN.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  // Master 0 (instruction)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [2:0]      m0_cti_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // Master 1 (data)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [2:0]      m1_cti_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // Shared slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [2:0]      s_cti_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  arb_state_e state_q, state_d;
  gnt_idx_t   prio_q, prio_d;
  gnt_idx_t   rr_idx;
  logic       rr_valid;
  logic       timeout;

  wb_arb_rr u_rr (
    .req_i   ({m1_cyc_i, m0_cyc_i}),
    .prio_i  (prio_q),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Request/response routing; everything is quiet outside the two grant states.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) state_d = rr_idx ? StGnt1 : StGnt0;
      end
      StGnt0: begin
        if (timeout || !m0_cyc_i) begin
          state_d = timeout ? StAbort : StIdle;
          prio_d  = 1'b1;
        end
      end
      StGnt1: begin
        if (timeout || !m1_cyc_i) begin
          state_d = timeout ? StAbort : StIdle;
          prio_d  = 1'b0;
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts stalled strobe cycles; the final stalled cycle fires the abort instead.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (s_stb_o && !s_ack_i && !s_err_i) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                    cnt_d   = cnt_q + 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
`endif

  assign gnt_o = {state_q == StGnt1, state_q == StGnt0};

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Scoreboard bench for wb_sdram_arbiter: directed transfers, expected responses queued in
// completion order and checked by an independent response monitor.
module tb_wb_sdram_arbiter;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = '0, m0_dat = '0;
  logic [3:0]  m0_sel = '0;
  logic [2:0]  m0_cti = '0;
  logic [31:0] m0_rdat;
  logic        m0_ack, m0_err;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = '0, m1_dat = '0;
  logic [3:0]  m1_sel = '0;
  logic [2:0]  m1_cti = '0;
  logic [31:0] m1_rdat;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [31:0] s_rdat = '0;
  logic        s_ack = 1'b0, s_err = 1'b0;
  logic [1:0]  gnt;

  logic        slv_en = 1'b1;
  logic        late_ack = 1'b0;

  typedef struct packed {
    logic        m;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_sdram_arbiter #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0_cyc_i   (m0_cyc),
    .m0_stb_i   (m0_stb),
    .m0_we_i    (m0_we),
    .m0_adr_i   (m0_adr),
    .m0_dat_i   (m0_dat),
    .m0_sel_i   (m0_sel),
    .m0_cti_i   (m0_cti),
    .m0_dat_o   (m0_rdat),
    .m0_ack_o   (m0_ack),
    .m0_err_o   (m0_err),
    .m1_cyc_i   (m1_cyc),
    .m1_stb_i   (m1_stb),
    .m1_we_i    (m1_we),
    .m1_adr_i   (m1_adr),
    .m1_dat_i   (m1_dat),
    .m1_sel_i   (m1_sel),
    .m1_cti_i   (m1_cti),
    .m1_dat_o   (m1_rdat),
    .m1_ack_o   (m1_ack),
    .m1_err_o   (m1_err),
    .s_cyc_o    (s_cyc),
    .s_stb_o    (s_stb),
    .s_we_o     (s_we),
    .s_adr_o    (s_adr),
    .s_dat_o    (s_wdat),
    .s_sel_o    (s_sel),
    .s_cti_o    (s_cti),
    .s_dat_i    (s_rdat),
    .s_ack_i    (s_ack),
    .s_err_i    (s_err),
    .gnt_o      (gnt)
  );

  // Slave: one wait state per beat. Reads return adr + {sel, 28'h0}, writes echo the data,
  // address 0xBAD00000 answers with err.
  always @(posedge clk) begin
    s_ack  <= late_ack;
    s_err  <= 1'b0;
    s_rdat <= '0;
    if (s_cyc && s_stb && !s_ack && !s_err && slv_en) begin
      if (s_adr == 32'hBAD0_0000) begin
        s_err <= 1'b1;
      end else begin
        s_ack  <= 1'b1;
        s_rdat <= s_we ? s_wdat : s_adr + {s_sel, 28'h0};
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input logic m, input logic [31:0] d, input logic e);
    exp_t x;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL resp: unexpected m%0d dat=%h err=%b, required no response", m, d, e);
      return;
    end
    x = exp_q.pop_front();
    if (x.m != m || x.err != e || (!e && x.dat != d)) begin
      n_bad++;
      $display("FAIL resp: got m%0d dat=%h err=%b, required m%0d dat=%h err=%b",
               m, d, e, x.m, x.dat, x.err);
    end
  endtask

  always @(negedge clk) begin
    if (m0_ack && m1_ack) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_excl: got both acks, required at most one");
    end
    if (m0_ack || m0_err) check_resp(1'b0, m0_rdat, m0_err);
    if (m1_ack || m1_err) check_resp(1'b1, m1_rdat, m1_err);
  end

  task automatic push(input logic m, input logic [31:0] dat, input logic err);
    exp_t x;
    x.m   = m;
    x.dat = dat;
    x.err = err;
    exp_q.push_back(x);
  endtask

  task automatic drive_req(input logic m, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
    if (!m) begin
      m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_cti = cti;
    end else begin
      m1_cyc = 1; m1_stb = 1; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_cti = cti;
    end
  endtask

  task automatic release_m(input logic m);
    @(posedge clk);
    #1;
    if (!m) begin m0_cyc = 0; m0_stb = 0; m0_we = 0; end
    else    begin m1_cyc = 0; m1_stb = 0; m1_we = 0; end
  endtask

  task automatic wait_resp(input logic m, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!m ? (m0_ack || m0_err) : (m1_ack || m1_err)) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_m%0d: no response after %0d cycles, required ack or err", m, limit);
  endtask

  task automatic do_reset();
    rst_n = 0;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int errs;
    int bad_gnt;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}, 64'h0);
    rst_n = 1;

    // Single m0 read, 1-cycle arbitration latency
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    drive_req(1'b0, 32'hEEAD_BEEF, 1'b0, '0, 4'hF, CtiClassic);
    @(negedge clk);
    check("lat_cycle1", {gnt, s_cyc}, 64'h0);
    @(negedge clk);
    check("lat_cycle2", {gnt, s_cyc}, {61'h0, 2'b01, 1'b1});
    check("adr_fwd", s_adr, 64'hEEAD_BEEF);
    wait_resp(1'b0, 20);
    check("m1_quiet", {m1_ack, m1_err, m1_rdat}, 64'h0);
    release_m(1'b0);

    // Simultaneous requests after reset: m0, then m1, then m0 again
    do_reset();
    push(1'b0, 32'hF000_0010, 1'b0);
    push(1'b1, 32'hF000_0020, 1'b0);
    push(1'b0, 32'hF000_0030, 1'b0);
    @(posedge clk); #1;
    drive_req(1'b0, 32'h10, 1'b0, '0, 4'hF, CtiClassic);
    drive_req(1'b1, 32'h20, 1'b0, '0, 4'hF, CtiClassic);
    fork
      begin
        wait_resp(1'b1, 60);
        release_m(1'b1);
      end
    join_none
    wait_resp(1'b0, 20);
    release_m(1'b0);
    @(negedge clk); check("b2b_hold0", gnt, 64'b01);
    @(negedge clk); check("b2b_idle0", gnt, 64'b00);
    @(negedge clk); check("b2b_gnt1", gnt, 64'b10);
    @(posedge clk); #1;
    drive_req(1'b0, 32'h30, 1'b0, '0, 4'hF, CtiClassic);
    wait fork;
    @(negedge clk); check("b2b_hold1", gnt, 64'b10);
    @(negedge clk); check("b2b_idle1", gnt, 64'b00);
    @(negedge clk); check("b2b_gnt0", gnt, 64'b01);
    wait_resp(1'b0, 20);
    release_m(1'b0);

    // m1 8-beat burst holds the bus while m0 waits
    for (int i = 0; i < 8; i++) push(1'b1, 32'hF000_0200 + 32'(4 * i), 1'b0);
    push(1'b0, 32'h3000_0044, 1'b0);
    fork
      begin
        @(posedge clk); @(posedge clk); #1;
        drive_req(1'b0, 32'h44, 1'b0, '0, 4'h3, CtiClassic);
        wait_resp(1'b0, 100);
        release_m(1'b0);
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_req(1'b1, 32'h200 + 32'(4 * i), 1'b0, '0, 4'hF, (i == 7) ? CtiEob : CtiIncr);
      wait_resp(1'b1, 20);
      check("burst_gnt", gnt, 64'b10);
    end
    release_m(1'b1);
    wait fork;

    // m1 write echo and m0 slave error
    push(1'b1, 32'h1234_5678, 1'b0);
    push(1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    drive_req(1'b1, 32'h100, 1'b1, 32'h1234_5678, 4'hF, CtiClassic);
    wait_resp(1'b1, 20);
    release_m(1'b1);
    @(posedge clk); #1;
    drive_req(1'b0, 32'hBAD0_0000, 1'b0, '0, 4'hF, CtiClassic);
    wait_resp(1'b0, 20);
    release_m(1'b0);

    // Reset during an m0 wait state; a late ack must be dropped
    slv_en = 0;
    @(posedge clk); #1;
    drive_req(1'b0, 32'h50, 1'b0, '0, 4'hF, CtiClassic);
    repeat (3) @(negedge clk);
    check("wait_gnt", gnt, 64'b01);
    #2 rst_n = 0;
    #1;
    check("rst_ctl", {s_cyc, s_stb, s_we, gnt, m0_ack, m0_err, m1_ack, m1_err}, 64'h0);
    check("rst_dat", {s_adr, m0_rdat}, 64'h0);
    late_ack = 1;
    repeat (2) @(negedge clk);
    check("rst_late_ack", {m0_ack, m1_ack, s_ack}, 64'b001);
    m0_cyc = 0; m0_stb = 0;
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ack", {m0_ack, m1_ack, s_cyc}, 64'h0);
    late_ack = 0;

    // Slave never acks m0 while m1 is pending (prio back at m0 after reset)
    @(posedge clk); #1;
    drive_req(1'b0, 32'h60, 1'b0, '0, 4'hF, CtiClassic);
    drive_req(1'b1, 32'h70, 1'b0, '0, 4'hF, CtiClassic);
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
    push(1'b0, 32'h0, 1'b1);
    push(1'b1, 32'hF000_0070, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10 && !s_stb; i++) @(negedge clk);
    cnt = 1;
    for (int i = 0; i < 40 && !m0_err; i++) begin
      @(negedge clk);
      cnt++;
    end
    // err is raised in the 16th cycle that s_stb_o is high
    check("timeout_cycle", cnt, 64'd16);
    @(negedge clk);
    check("abort_quiet", {gnt, s_cyc}, 64'h0);
    slv_en = 1;
    release_m(1'b0);
    wait_resp(1'b1, 20);
    check("after_abort_gnt", gnt, 64'b10);
    release_m(1'b1);
`else
    push(1'b0, 32'hF000_0060, 1'b0);
    push(1'b1, 32'hF000_0070, 1'b0);
    errs = 0;
    bad_gnt = 0;
    @(negedge clk);
    repeat (10000) begin
      @(negedge clk);
      if (m0_err) errs++;
      if (gnt !== 2'b01) bad_gnt++;
    end
    check("no_timeout_err", errs, 64'd0);
    check("gnt_held", bad_gnt, 64'd0);
    slv_en = 1;
    wait_resp(1'b0, 20);
    release_m(1'b0);
    wait_resp(1'b1, 20);
    release_m(1'b1);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles without ack before abort.
REQ-004 SHALL have port wb_clk_i, input, 1, single clock; all logic in this domain.
REQ-005 SHALL have port wb_rst_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports m0_cyc_i/m0_stb_i/m0_we_i (input, 1), m0_adr_i (input, AW), m0_dat_i (input, DW), m0_sel_i (input, DW/8) and m0_cti_i (input, 3): master 0 (instruction) request.
REQ-007 SHALL have ports m0_dat_o (output, DW) and m0_ack_o/m0_err_o (output, 1): master 0 response.
REQ-008 SHALL have ports m1_* identical to m0_*: master 1 (data) request and response.
REQ-009 SHALL have ports s_cyc_o/s_stb_o/s_we_o (output, 1), s_adr_o (output, AW), s_dat_o (output, DW), s_sel_o (output, DW/8) and s_cti_o (output, 3): shared SDRAM-controller slave request.
REQ-010 SHALL have ports s_dat_i (input, DW) and s_ack_i/s_err_i (input, 1): slave response.
REQ-011 SHALL have port gnt_o, output, 2, one-hot current grant (debug).

Function
REQ-012 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT.
REQ-013 In IDLE, a single master asserting cyc SHALL move to that master's GNTx at the next edge; the slave sees s_cyc_o one cycle after the request (1-cycle arbitration latency).
REQ-014 When both cyc are asserted in IDLE, grant SHALL go to the master selected by the round-robin pointer prio; prio resets to master 0.
REQ-015 On leaving GNTx, prio SHALL point to the other master.
REQ-016 In GNTx, the granted master's request signals SHALL drive s_* combinationally, and s_dat_i/s_ack_i/s_err_i SHALL route to that master only.
REQ-017 The non-granted master SHALL see ack=0, err=0 and dat=0; its stb SHALL be ignored.
REQ-018 Grant SHALL be held while the granted cyc stays high, including multi-beat cti bursts (bus lock); GNTx->IDLE SHALL occur on the edge where the granted cyc is sampled low.
REQ-019 In IDLE and ABORT, all s_* outputs SHALL be 0.
REQ-020 A slave ack or err arriving while not in GNTx SHALL be dropped.
REQ-021 Back-to-back: master 1 waiting while master 0 releases SHALL be granted with exactly one IDLE cycle between cycles.

Reset
REQ-022 Asserting wb_rst_n_i low SHALL force, asynchronously: state=IDLE, prio=0, gnt_o=0, all s_* and m*_ack/err/dat outputs = 0, timeout counter=0.
REQ-023 Reset mid-transfer SHALL abort immediately; no ack SHALL be forwarded after reset.
REQ-024 Reset release SHALL be synchronous to wb_clk_i at its first rising edge.

Configuration
REQ-025 Macro WB_SDRAM_ARBITER_TIMEOUT_EN SHALL compile in the watchdog.
REQ-026 With the macro defined: a counter SHALL increment each GNTx cycle with s_stb_o=1 and no ack/err, and clear on ack/err or state change.
REQ-027 With the macro defined: when the counter reaches TIMEOUT_CYCLES-1, the granted master SHALL receive err for one cycle, followed by ABORT (1 cycle, s_cyc_o=0), then IDLE, with prio advanced.
REQ-028 Without the macro: no counter, ABORT unreachable, and the arbiter waits indefinitely.

Structure
REQ-029 Shared package wb_arb_pkg SHALL hold the state enum, CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111) and the grant-index type.
REQ-030 Single sub-module wb_arb_rr (2-way round-robin pick from req and prio) SHALL be used; muxing and FSM stay in top.

Verification
REQ-031 Reset, m0 single read: s_cyc_o high on cycle 2; slave acks with 0xDEADBEEF -> m0_dat_o=0xDEADBEEF, m0_ack_o=1, m1_ack_o=0.
REQ-032 m0 and m1 both request in the same cycle after reset -> m0 granted first; m1 granted after m0 drops cyc, with 1 IDLE cycle; m0 requesting again next -> m1 finishes, then m0.
REQ-033 m1 8-beat INCR burst (cti 010 x7, 111 last) with m0 requesting throughout -> gnt_o stays 2'b10 for all 8 acks.
REQ-034 wb_rst_n_i pulsed low during an m0 wait state -> all outputs 0 in the same cycle; a late slave ack is not forwarded.
REQ-035 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never acks m0 -> m0_err_o=1 exactly 16 cycles after s_stb_o rises, then s_cyc_o=0 for 1 cycle, then pending m1 granted.
REQ-036 TIMEOUT_EN undefined, same stimulus as REQ-035 -> no err after 10000 cycles and gnt_o held at 2'b01.
